// File: rtl/eth_pkg.sv
// Shared types and constants for the MII transmit path.
package eth_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SFD,
        S_DATA_LO,
        S_DATA_HI,
        S_UNDERRUN,
        S_FLUSH,
        S_IFG
    } tx_state_e;

    localparam logic [3:0]  PREAMBLE_NIBBLE = 4'h5;
    localparam logic [3:0]  SFD_NIBBLE      = 4'hD;
    localparam int unsigned CRC_BYTES       = 4;
    localparam int unsigned WC_WIDTH        = 11;
    localparam int unsigned LEN_WIDTH       = WC_WIDTH + 1;

endpackage

// File: rtl/eth_tx_sequencer_sync_ff.sv
// Multi-stage single-bit synchroniser; q is the last stage of the chain.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d    = sync_q << 1;
        sync_d[0] = d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/eth_tx_sequencer.sv
// MII transmit frame controller: descriptor handshake, preamble/SFD, nibble
// serialisation of FIFO bytes, underrun flush and inter-frame gap.
module eth_tx_sequencer
    import eth_pkg::*;
#(
    parameter int unsigned PREAMBLE_NIBBLES = 15,
    parameter int unsigned IFG_CYCLES       = 24,
    parameter int unsigned SYNC_STAGES      = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WC_WIDTH-1:0] i_word_count,
    input  logic                i_word_count_ready,
    output logic                o_word_count_ack,
    input  logic [7:0]          i_fifo_data,
    input  logic                i_fifo_empty,
    output logic                o_fifo_rd,
    output logic [3:0]          o_mii_txd,
    output logic                o_mii_tx_en,
    output logic                o_busy,
    output logic                o_underrun
);

    localparam int unsigned CNT_MAX = (PREAMBLE_NIBBLES > IFG_CYCLES) ? PREAMBLE_NIBBLES : IFG_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    tx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0] rem_q, rem_d;
    logic [3:0]           hold_q, hold_d;
    logic                 ack_q, ack_d;
    logic                 ready_s;

    sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_ready_sync (
        .clk(clk),
        .rst(rst),
        .d  (i_word_count_ready),
        .q  (ready_s)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        rem_d       = rem_q;
        hold_d      = hold_q;
        ack_d       = ack_q;
        o_mii_txd   = '0;
        o_mii_tx_en = 1'b0;
        o_fifo_rd   = 1'b0;
        o_underrun  = 1'b0;

        // Ack release is independent of the frame state.
        if (ack_q && !ready_s) begin
            ack_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (ready_s && !ack_q) begin
                    rem_d   = LEN_WIDTH'(i_word_count) + LEN_WIDTH'(CRC_BYTES);
                    ack_d   = 1'b1;
                    state_d = S_PREAMBLE;
                end
            end
            S_PREAMBLE: begin
                o_mii_tx_en = 1'b1;
                o_mii_txd   = PREAMBLE_NIBBLE;
                if (cnt_q == CNT_W'(PREAMBLE_NIBBLES - 1)) begin
                    state_d = S_SFD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SFD: begin
                o_mii_tx_en = 1'b1;
                o_mii_txd   = SFD_NIBBLE;
                if (!i_fifo_empty) begin
                    o_fifo_rd = 1'b1;
                    state_d   = S_DATA_LO;
                end else begin
                    state_d = S_UNDERRUN;
                end
            end
            S_DATA_LO: begin
                o_mii_tx_en = 1'b1;
                o_mii_txd   = i_fifo_data[3:0];
                hold_d      = i_fifo_data[7:4];
                rem_d       = rem_q - LEN_WIDTH'(1);
                state_d     = S_DATA_HI;
            end
            S_DATA_HI: begin
                o_mii_tx_en = 1'b1;
                o_mii_txd   = hold_q;
                if (rem_q == '0) begin
                    state_d = S_IFG;
                end else if (!i_fifo_empty) begin
                    o_fifo_rd = 1'b1;
                    state_d   = S_DATA_LO;
                end else begin
                    state_d = S_UNDERRUN;
                end
            end
            S_UNDERRUN: begin
                o_underrun = 1'b1;
                state_d    = S_FLUSH;
            end
            S_FLUSH: begin
                if (rem_q == '0) begin
                    state_d = S_IFG;
                end else if (!i_fifo_empty) begin
                    o_fifo_rd = 1'b1;
                    rem_d     = rem_q - LEN_WIDTH'(1);
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state_d = S_IFG;
                    end
                end
            end
            S_IFG: begin
                if (cnt_q == CNT_W'(IFG_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            hold_q  <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            hold_q  <= hold_d;
            ack_q   <= ack_d;
        end
    end

    assign o_word_count_ack = ack_q;
    assign o_busy           = (state_q != S_IDLE);

endmodule
